// File: rtl/picomips_pkg.sv
// Shared types for the picoMips controller: opcode and state encodings,
// instruction field positions and the per-opcode control decode.
package picomips_pkg;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int REG_MSB = 11;
  localparam int REG_LSB = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LDI   = 4'h1,
    OP_LDSW  = 4'h2,
    OP_LDR   = 4'h3,
    OP_ADDI  = 4'h4,
    OP_ADDR  = 4'h5,
    OP_MULI  = 4'h6,
    OP_STR   = 4'h7,
    OP_BRA   = 4'h8,
    OP_BZ    = 4'h9,
    OP_BNEG  = 4'hA,
    OP_WAITB = 4'hB,
    OP_HALT  = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    WAITP,
    WAITR,
    HALT
  } state_t;

  typedef struct packed {
    logic we;
    logic reg_we;
    logic sel_imm;
    logic sel_sw;
    logic sel_reg;
    logic use_mul;
    logic use_acc;
  } ctrl_t;

  // Control pattern of one opcode; reserved codes (C..E) fall through as NOP.
  function automatic ctrl_t decode_ctrl(input logic [3:0] opc);
    ctrl_t c;
    c = '0;
    case (opc)
      OP_LDI:  begin c.we = 1'b1; c.sel_imm = 1'b1; end
      OP_LDSW: begin c.we = 1'b1; c.sel_sw  = 1'b1; end
      OP_LDR:  begin c.we = 1'b1; c.sel_reg = 1'b1; end
      OP_ADDI: begin c.we = 1'b1; c.sel_imm = 1'b1; c.use_acc = 1'b1; end
      OP_ADDR: begin c.we = 1'b1; c.sel_reg = 1'b1; c.use_acc = 1'b1; end
      OP_MULI: begin c.we = 1'b1; c.use_mul = 1'b1; c.use_acc = 1'b1; end
      OP_STR:  c.reg_we = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/picomips_if.sv
// Controller-side bus of picoMips: ROM address/data, ALU controls and
// register-file port. master = controller, slave = datapath + ROM.
interface picomips_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
);
  logic [PC_W-1:0]    PC;
  logic [INSTR_W-1:0] Instr;
  logic [7:0]         ACC;
  logic [7:0]         Imm;
  logic [3:0]         RegAddr;
  logic               RegWE;
  logic               WE;
  logic               SelImm;
  logic               SelSW;
  logic               SelReg;
  logic               UseMul;
  logic               UseACC;
  logic               Halted;

  modport master (
    output PC, Imm, RegAddr, RegWE, WE, SelImm, SelSW, SelReg, UseMul, UseACC, Halted,
    input  Instr, ACC
  );

  modport slave (
    input  PC, Imm, RegAddr, RegWE, WE, SelImm, SelSW, SelReg, UseMul, UseACC, Halted,
    output Instr, ACC
  );
endinterface

// File: rtl/picomips_btn_sync.sv
// Two-flop synchroniser for the asynchronous push-button input.
module btn_sync (
  input  logic Clock,
  input  logic nReset,
  input  logic d,
  output logic q
);
  logic meta;

  // NOTE: clocked state uses non-blocking assignments so meta->q shifts by one stage per edge.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/picomips_ctrl.sv
// picoMips sequencer: FETCH/EXEC instruction loop with branch evaluation on ACC,
// a push-button wait handshake and a terminal HALT state.
module picomips_ctrl
  import picomips_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       Btn,
  picomips_if.master bus
);

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic               btn_s;
  logic [3:0]         opc;
  logic [7:0]         imm;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    target;
  ctrl_t              ctl;

  btn_sync u_btn_sync (
    .Clock  (Clock),
    .nReset (nReset),
    .d      (Btn),
    .q      (btn_s)
  );

  assign opc    = ir[OPC_MSB:OPC_LSB];
  assign imm    = ir[IMM_MSB:IMM_LSB];
  assign pc_inc = pc + PC_W'(1);
  assign target = PC_W'(imm);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          ir    <= bus.Instr;
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          pc    <= pc_inc;
          // ACC seen here is the previous instruction's settled result.
          case (opc)
            OP_BRA:   pc <= target;
            OP_BZ:    if (bus.ACC == 8'h00) pc <= target;
            OP_BNEG:  if (bus.ACC[7]) pc <= target;
            OP_WAITB: begin
              pc    <= pc;
              state <= WAITP;
            end
            OP_HALT:  begin
              pc    <= pc;
              state <= HALT;
            end
            default:  ;
          endcase
        end
        WAITP: if (btn_s) state <= WAITR;
        WAITR: begin
          if (!btn_s) begin
            pc    <= pc_inc;
            state <= FETCH;
          end
        end
        HALT:    ;
        default: state <= FETCH;
      endcase
    end
  end

  // Enables exist only in EXEC; IR and state reset asynchronously, so they drop with nReset.
  // NOTE: the default assignment first keeps this always_comb free of inferred latches.
  always_comb begin
    ctl = '0;
    if (state == EXEC) ctl = decode_ctrl(opc);
  end

  assign bus.PC      = pc;
  assign bus.Imm     = imm;
  assign bus.RegAddr = ir[REG_MSB:REG_LSB];
  assign bus.WE      = ctl.we;
  assign bus.RegWE   = ctl.reg_we;
  assign bus.SelImm  = ctl.sel_imm;
  assign bus.SelSW   = ctl.sel_sw;
  assign bus.SelReg  = ctl.sel_reg;
  assign bus.UseMul  = ctl.use_mul;
  assign bus.UseACC  = ctl.use_acc;
  assign bus.Halted  = (state == HALT);

endmodule

// File: tb/tb_picomips_ctrl.sv
// Scoreboard bench for picomips_ctrl: directed programs push expected PC/write/halt
// events; a negedge monitor pops and compares each event the controller produces.
module tb_picomips_ctrl;

  typedef enum logic [1:0] {EV_PC, EV_WR, EV_HLT} ev_kind_t;

  typedef struct {
    ev_kind_t   kind;
    logic [7:0] pc;
    logic [6:0] ctl;
    logic [3:0] ra;
    int         cyc;
  } ev_t;

  // {WE, RegWE, SelImm, SelSW, SelReg, UseMul, UseACC}
  localparam logic [6:0] C_WE  = 7'b1000000;
  localparam logic [6:0] C_RWE = 7'b0100000;
  localparam logic [6:0] C_IMM = 7'b0010000;
  localparam logic [6:0] C_SW  = 7'b0001000;
  localparam logic [6:0] C_REG = 7'b0000100;
  localparam logic [6:0] C_MUL = 7'b0000010;
  localparam logic [6:0] C_ACC = 7'b0000001;

  logic        Clock;
  logic        nReset;
  logic        Btn;
  logic [7:0]  acc;
  logic [15:0] rom [256];
  logic [15:0] rom_q;
  int          cyc;
  int          total;
  int          bad;
  bit          mon_en;
  string       tname;
  ev_t         exp_q[$];
  logic [7:0]  prev_pc;
  logic        prev_halted;
  logic [6:0]  ctl_now;

  picomips_if #(.PC_W(8), .INSTR_W(16)) bus ();

  picomips_ctrl #(.PC_W(8), .INSTR_W(16)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .Btn    (Btn),
    .bus    (bus)
  );

  assign bus.Instr = rom_q;
  assign bus.ACC   = acc;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Program ROM: data for the presented PC is ready before the FETCH edge.
  always @(negedge Clock) rom_q <= rom[bus.PC];

  always @(posedge Clock or negedge nReset) begin
    if (!nReset) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [7:0] pc, input logic [6:0] ctl,
                           input logic [3:0] ra, input int c);
    ev_t e;
    e.kind = k; e.pc = pc; e.ctl = ctl; e.ra = ra; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input logic [6:0] ctl, input logic [3:0] ra);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_unexpected: got kind %0d pc %0h expected no event (cyc %0d)",
               tname, k, bus.PC, cyc);
    end else begin
      e = exp_q.pop_front();
      check({tname, "_kind"}, 32'(k), 32'(e.kind));
      check({tname, "_pc"}, 32'(bus.PC), 32'(e.pc));
      check({tname, "_cyc"}, cyc, e.cyc);
      if (e.kind == EV_WR) begin
        check({tname, "_ctl"}, 32'(ctl), 32'(e.ctl));
        check({tname, "_regaddr"}, 32'(ra), 32'(e.ra));
      end
    end
  endtask

  always @(negedge Clock) begin
    if (!nReset) begin
      prev_pc     = '0;
      prev_halted = 1'b0;
    end else begin
      ctl_now = {bus.WE, bus.RegWE, bus.SelImm, bus.SelSW, bus.SelReg, bus.UseMul, bus.UseACC};
      if (mon_en) begin
        if (bus.PC != prev_pc)             observe(EV_PC, ctl_now, bus.RegAddr);
        if (bus.WE || bus.RegWE)           observe(EV_WR, ctl_now, bus.RegAddr);
        if (bus.Halted && !prev_halted)    observe(EV_HLT, ctl_now, bus.RegAddr);
        if (ctl_now[4:2] != 3'b000)        check({tname, "_sel_onehot"}, $countones(ctl_now[4:2]), 1);
      end
      prev_pc     = bus.PC;
      prev_halted = bus.Halted;
    end
  end

  task automatic start_test(input string name);
    tname   = name;
    nReset  = 1'b0;
    Btn     = 1'b0;
    acc     = 8'h00;
    mon_en  = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    repeat (2) @(negedge Clock);
  endtask

  task automatic release_rst();
    @(negedge Clock);
    nReset = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge Clock);
      n++;
    end
    check({tname, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (4) @(negedge Clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;

    // Reset values while nReset is held low.
    start_test("reset_state");
    check("rst_pc", bus.PC, 0);
    check("rst_we", bus.WE, 0);
    check("rst_regwe", bus.RegWE, 0);
    check("rst_sels", {bus.SelImm, bus.SelSW, bus.SelReg, bus.UseMul, bus.UseACC}, 0);
    check("rst_halted", bus.Halted, 0);
    check("rst_imm", bus.Imm, 0);

    // LDI 5; ADDI 3; STR r2; HALT
    start_test("basic");
    rom[0] = 16'h1005; rom[1] = 16'h4003; rom[2] = 16'h7200; rom[3] = 16'hF000;
    expect_ev(EV_WR,  8'h00, C_WE | C_IMM,         4'h0, 1);
    expect_ev(EV_PC,  8'h01, '0,                   4'h0, 2);
    expect_ev(EV_WR,  8'h01, C_WE | C_IMM | C_ACC, 4'h0, 3);
    expect_ev(EV_PC,  8'h02, '0,                   4'h0, 4);
    expect_ev(EV_WR,  8'h02, C_RWE,                4'h2, 5);
    expect_ev(EV_PC,  8'h03, '0,                   4'h0, 6);
    expect_ev(EV_HLT, 8'h03, '0,                   4'h0, 8);
    release_rst();
    drain(40);

    // LDSW; LDR r5; ADDR r6; reserved C; HALT
    start_test("decode");
    rom[0] = 16'h2000; rom[1] = 16'h3500; rom[2] = 16'h5600; rom[3] = 16'hC000; rom[4] = 16'hF000;
    expect_ev(EV_WR,  8'h00, C_WE | C_SW,          4'h0, 1);
    expect_ev(EV_PC,  8'h01, '0,                   4'h0, 2);
    expect_ev(EV_WR,  8'h01, C_WE | C_REG,         4'h5, 3);
    expect_ev(EV_PC,  8'h02, '0,                   4'h0, 4);
    expect_ev(EV_WR,  8'h02, C_WE | C_REG | C_ACC, 4'h6, 5);
    expect_ev(EV_PC,  8'h03, '0,                   4'h0, 6);
    expect_ev(EV_PC,  8'h04, '0,                   4'h0, 8);
    expect_ev(EV_HLT, 8'h04, '0,                   4'h0, 10);
    release_rst();
    drain(40);

    start_test("bz_taken");
    rom[0] = 16'h9040; rom[1] = 16'hF000; rom[8'h40] = 16'hF000;
    acc = 8'h00;
    expect_ev(EV_PC,  8'h40, '0, 4'h0, 2);
    expect_ev(EV_HLT, 8'h40, '0, 4'h0, 4);
    release_rst();
    drain(40);

    start_test("bz_not_taken");
    rom[0] = 16'h9040; rom[1] = 16'hF000; rom[8'h40] = 16'hF000;
    acc = 8'h01;
    expect_ev(EV_PC,  8'h01, '0, 4'h0, 2);
    expect_ev(EV_HLT, 8'h01, '0, 4'h0, 4);
    release_rst();
    drain(40);

    start_test("bneg_taken");
    rom[0] = 16'hA040; rom[1] = 16'hF000; rom[8'h40] = 16'hF000;
    acc = 8'h80;
    expect_ev(EV_PC,  8'h40, '0, 4'h0, 2);
    expect_ev(EV_HLT, 8'h40, '0, 4'h0, 4);
    release_rst();
    drain(40);

    start_test("bneg_not_taken");
    rom[0] = 16'hA040; rom[1] = 16'hF000; rom[8'h40] = 16'hF000;
    acc = 8'h7F;
    expect_ev(EV_PC,  8'h01, '0, 4'h0, 2);
    expect_ev(EV_HLT, 8'h01, '0, 4'h0, 4);
    release_rst();
    drain(40);

    // WAITB; MULI 0x40; BRA 0xFF; NOP at 0xFF wraps to WAITB again
    start_test("waitb_wrap");
    rom[0] = 16'hB000; rom[1] = 16'h6040; rom[2] = 16'h80FF; rom[8'hFF] = 16'h0000;
    expect_ev(EV_PC, 8'h01, '0,                    4'h0, 16);
    expect_ev(EV_WR, 8'h01, C_WE | C_MUL | C_ACC,  4'h0, 17);
    expect_ev(EV_PC, 8'h02, '0,                    4'h0, 18);
    expect_ev(EV_PC, 8'hFF, '0,                    4'h0, 20);
    expect_ev(EV_PC, 8'h00, '0,                    4'h0, 22);
    release_rst();
    repeat (10) @(negedge Clock);
    Btn = 1'b1;
    repeat (3) @(negedge Clock);
    Btn = 1'b0;
    drain(60);

    // Button already held when WAITB is reached.
    start_test("waitb_prepressed");
    rom[0] = 16'hB000; rom[1] = 16'hF000;
    Btn = 1'b1;
    expect_ev(EV_PC,  8'h01, '0, 4'h0, 8);
    expect_ev(EV_HLT, 8'h01, '0, 4'h0, 10);
    release_rst();
    repeat (5) @(negedge Clock);
    Btn = 1'b0;
    drain(40);

    // Reset asserted in the middle of the LDI EXEC cycle.
    start_test("reset_abort");
    mon_en = 1'b0;
    rom[0] = 16'h0000; rom[1] = 16'h1022; rom[2] = 16'hF000;
    release_rst();
    repeat (3) @(posedge Clock);
    #2;
    check("abort_pre_we", bus.WE, 1);
    check("abort_pre_selimm", bus.SelImm, 1);
    check("abort_pre_pc", bus.PC, 8'h01);
    check("abort_pre_imm", bus.Imm, 8'h22);
    nReset = 1'b0;
    #1;
    check("abort_pc", bus.PC, 0);
    check("abort_we", bus.WE, 0);
    check("abort_selimm", bus.SelImm, 0);
    check("abort_imm", bus.Imm, 0);
    check("abort_halted", bus.Halted, 0);
    repeat (2) @(negedge Clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
